// File: rtl/rr_mux8_if.sv
// rr_mux8_if: bundle of the arbitrated 8-to-1 mux signals.
// Carries the eight producer request/data lanes, the grant pulses back to the
// producers, and the shared output link (dout, channel index a/b/c, strobe e,
// sink ready) plus the completed-transfer counter.
// The master modport is the mux itself; the slave modport is its environment
// (producers plus the sink on the output link).
interface rr_mux8_if #(
   parameter int DW = 8
);

   logic [7:0]      req;
   logic [8*DW-1:0] din;
   logic [7:0]      gnt;
   logic [DW-1:0]   dout;
   logic            a;
   logic            b;
   logic            c;
   logic            e;
   logic            out_ready;
   logic [15:0]     xfer_cnt;

   // The mux drives grants and the output link, and observes requests and ready.
   modport master (
      input  req,
      input  din,
      input  out_ready,
      output gnt,
      output dout,
      output a,
      output b,
      output c,
      output e,
      output xfer_cnt
   );

   // Producers and sink drive requests/data/ready and observe everything else.
   modport slave (
      output req,
      output din,
      output out_ready,
      input  gnt,
      input  dout,
      input  a,
      input  b,
      input  c,
      input  e,
      input  xfer_cnt
   );

endinterface

// File: rtl/rr_mux8.sv
// rr_mux8: 8-to-1 arbitrated multiplexer, sending end of a 3-bit select + enable
// link. Eight producers contend; one winner per capture has its word registered
// onto dout, with its channel index on {a,b,c} and the valid strobe on e.
// Build option: define FIXED_PRIO_EN for lowest-index-wins arbitration;
// left undefined, the arbiter is round-robin starting after the last winner.
// All outputs come straight from flops, so there is no input-to-output path.
module rr_mux8 #(
   parameter int DW = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux8_if.master   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q;
   logic [DW-1:0]   dout_q;
   logic [2:0]      abc_q;
   logic            e_q;
   logic [7:0]      gnt_q;
   logic [15:0]     xferCnt_q;

   logic [7:0]      eligible;
   logic            anyEligible;
   logic            handshake;
   logic            capture;
   logic [2:0]      winIdx_d;
   logic [DW-1:0]   winData_d;
   logic [7:0]      winOneHot_d;

   // A channel granted in the previous cycle is masked so its producer gets
   // one cycle to advance its data or drop its request before being re-picked.
   assign eligible    = bus.req & ~gnt_q;
   assign anyEligible = |eligible;

   // The output word leaves when the sink accepts it while the strobe is up.
   assign handshake   = e_q & bus.out_ready;

   // A new word is taken whenever the output register is free (idle) or is
   // being emptied this cycle, which keeps back-to-back throughput at 1/cycle.
   assign capture     = anyEligible & ((state_q == IDLE) | handshake);

`ifdef FIXED_PRIO_EN

   // Fixed priority: the lowest-numbered eligible channel always wins.
   always_comb begin
      logic found;
      found    = 1'b0;
      winIdx_d = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!found && eligible[i]) begin
            winIdx_d = 3'(i);
            found    = 1'b1;
         end
      end
   end

`else

   logic [2:0] ptr_q;

   // Round-robin: scan ptr+1, ptr+2, ... wrapping at 8, so the last winner is
   // considered last; the 3-bit add provides the modulo-8 wrap for free.
   always_comb begin
      logic       found;
      logic [2:0] cand;
      found    = 1'b0;
      cand     = 3'd0;
      winIdx_d = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr_q + 3'(k);
         if (!found && eligible[cand]) begin
            winIdx_d = cand;
            found    = 1'b1;
         end
      end
   end

   // The pointer remembers the most recent winner so the next search starts
   // just past it; reset parks it at 7 so channel 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 3'd7;
      end else if (capture) begin
         ptr_q <= winIdx_d;
      end
   end

`endif

   // Steer the winner's word out of the packed data bus and form its grant.
   always_comb begin
      winData_d   = '0;
      winOneHot_d = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (winIdx_d == 3'(i)) begin
            winData_d      = bus.din[i*DW +: DW];
            winOneHot_d[i] = 1'b1;
         end
      end
   end

   // Control FSM with registered outputs: IDLE means no word is presented,
   // HOLD means dout/abc/e are presented and frozen until the sink accepts.
   // Grants are single-cycle pulses, so the register defaults to zero and is
   // only loaded on a capture edge. When the output empties with nothing new
   // to send, dout and abc deliberately keep the last word for observability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dout_q    <= '0;
         abc_q     <= 3'd0;
         e_q       <= 1'b0;
         gnt_q     <= 8'd0;
         xferCnt_q <= 16'd0;
      end else begin
         gnt_q <= 8'd0;
         if (handshake) begin
            xferCnt_q <= xferCnt_q + 16'd1;
         end
         case (state_q)
            IDLE: begin
               if (capture) begin
                  state_q <= HOLD;
                  dout_q  <= winData_d;
                  abc_q   <= winIdx_d;
                  e_q     <= 1'b1;
                  gnt_q   <= winOneHot_d;
               end
            end
            HOLD: begin
               if (handshake) begin
                  if (capture) begin
                     dout_q <= winData_d;
                     abc_q  <= winIdx_d;
                     e_q    <= 1'b1;
                     gnt_q  <= winOneHot_d;
                  end else begin
                     state_q <= IDLE;
                     e_q     <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               e_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout     = dout_q;
   assign bus.a        = abc_q[2];
   assign bus.b        = abc_q[1];
   assign bus.c        = abc_q[0];
   assign bus.e        = e_q;
   assign bus.gnt      = gnt_q;
   assign bus.xfer_cnt = xferCnt_q;

endmodule
